usb_prot_ctrl: RTL and testbench
================================

Name: usb_prot_ctrl

Overview:
Protocol controller that sequences the shared 64-byte USB data buffer between the RX path (rx_db), the TX path and the host side. Tracks packet phase (receive, transmit, wait-for-handshake) and grants buffer ownership. Pulses buffer clear, launches TX packets and raises sticky status and error flags to the host register interface. Sits between rx_db/tx_db and the AHB-side register block.

Parameters:
BUF_DEPTH, 64, data buffer capacity in bytes
TIMEOUT_CYCLES, 150, clk cycles to wait for a host-bound handshake after TX data (about 18 bit times at 12 Mb/s on 100 MHz clk)
TX_START_WAIT, 8, maximum clk cycles from tx_start to tx_transfer_active before error

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous reset, active-high
rx_packet  in  3  decoded PID from RX (pkg usb_pid_t)
rx_data_ready  in  1  RX packet complete, 1-cycle pulse
rx_transfer_active  in  1  RX packet in progress
rx_error  in  1  RX framing/PID/overflow error, 1-cycle pulse
tx_transfer_active  in  1  TX serializer busy
tx_error  in  1  TX error pulse
buffer_occupancy  in  7  bytes currently in buffer, 0..BUF_DEPTH
host_tx_req  in  1  host request to send a packet, 1-cycle pulse
host_tx_pid  in  3  PID to send, sampled with host_tx_req
host_ack_clr  in  1  host clears status/error, 1-cycle pulse
tx_packet  out  3  PID driven to TX, held valid while TX runs
tx_start  out  1  1-cycle launch pulse to TX
clear  out  1  1-cycle buffer flush pulse
d_mode  out  1  buffer owner: 0 = host, 1 = USB
host_busy  out  1  controller not in IDLE
rx_pid_latched  out  3  PID of last good received packet
rx_size  out  7  buffer_occupancy latched at rx_data_ready
rx_done  out  1  sticky, last RX completed OK
ctrl_error  out  1  sticky error flag

Behaviour:
- Reset (rst high at posedge): state IDLE; all outputs 0; tx_packet = PID_NONE (3'd0).
- States: IDLE, RX_ACTIVE, TX_START, TX_ACTIVE, WAIT_HS, ERROR.
- IDLE: d_mode=0.
  - rx_transfer_active=1 -> RX_ACTIVE; clear not pulsed.
  - host_tx_req -> latch host_tx_pid into tx_packet, go to TX_START.
  - Both in the same cycle: RX wins; host_tx_req is dropped and ctrl_error is set.
- RX_ACTIVE: d_mode=1.
  - rx_data_ready -> latch rx_pid_latched, rx_size; set rx_done; return to IDLE next cycle.
  - rx_error -> ERROR, with clear pulsed on the transition cycle.
  - rx_error and rx_data_ready in the same cycle: error wins.
- TX_START: tx_start=1 for exactly one cycle, d_mode=1.
  - Then wait for tx_transfer_active; enter TX_ACTIVE when it rises.
  - No rise within TX_START_WAIT cycles -> ERROR.
- TX_ACTIVE: leave on falling edge of tx_transfer_active.
  - PID DATA0/DATA1 -> WAIT_HS.
  - Handshake PIDs (ACK/NAK/STALL) -> IDLE.
  - tx_error -> ERROR.
- WAIT_HS: counter from 0; rx_transfer_active before TIMEOUT_CYCLES-1 -> RX_ACTIVE (handshake reception); counter reaching TIMEOUT_CYCLES-1 -> ERROR (counter saturates, no wrap).
- ERROR: ctrl_error=1, d_mode=0; -> IDLE on host_ack_clr.
- host_ack_clr in any state: clears rx_done and ctrl_error, same cycle.
- Buffer clear:
  - clear pulses one cycle on IDLE->TX_START only when tx_packet is a handshake PID, so stale RX data never goes out.
  - A host_tx_req while rx_done=1 and PID is DATA keeps the buffer.
- Overflow: buffer_occupancy > BUF_DEPTH in RX_ACTIVE -> ERROR.
- Latency: host_tx_req to tx_start is 1 cycle; rx_data_ready to rx_done is 1 cycle.
- rst mid-transfer: immediate return to IDLE with outputs at reset values; no clear pulse.

Optional Feature:
USB_NAK_RETRY_EN:
- Defined: in RX_ACTIVE after WAIT_HS, a received NAK relaunches the same DATA PID via TX_START, up to 3 retries (2-bit counter), without clearing the buffer. The 4th NAK -> ERROR.
- Undefined: NAK is latched as a normal packet and the controller goes to IDLE.

Decomposition:
- Package usb_pkg: usb_pid_t enum (NONE=0, OUT=1, IN=2, DATA0=3, DATA1=4, ACK=5, NAK=6, STALL=7), ctrl_state_t enum, BUF_DEPTH constant.
- One sub-module, usb_timeout_cnt: loadable saturating counter used for WAIT_HS and the TX_START guard.

Test Plan:
- RX DATA0 with 1 data byte: rx_transfer_active 1, then rx_data_ready with occupancy 1 -> rx_done=1, rx_size=1, rx_pid_latched=3, d_mode back to 0.
- host_tx_req PID=ACK from IDLE -> clear and tx_start pulse one cycle later; tx_packet=5; TX done -> IDLE.
- host_tx_req PID=DATA1 with 64 bytes buffered -> no clear; WAIT_HS; no RX for 150 cycles -> ctrl_error=1; host_ack_clr -> IDLE, flag 0.
- rx_error mid-RX -> clear pulse, ERROR, ctrl_error=1, rx_done unchanged.
- Simultaneous rx_transfer_active and host_tx_req in IDLE -> RX_ACTIVE, no tx_start, ctrl_error=1.
- rst asserted in TX_ACTIVE -> next cycle all outputs 0, tx_packet=0, state IDLE.

Source files
------------

// File: rtl/usb_pkg.sv
// usb_pkg: shared types and constants for the USB protocol controller.
//   usb_pid_t    - 3-bit decoded PID encoding shared by RX, TX and the controller
//   ctrl_state_t - protocol controller phase
//   BUF_DEPTH    - default data buffer capacity in bytes
//   helpers      - PID class tests and buffer-ownership decode per state
package usb_pkg;

  localparam int BUF_DEPTH = 64;

  typedef enum logic [2:0] {
    PID_NONE  = 3'd0,
    PID_OUT   = 3'd1,
    PID_IN    = 3'd2,
    PID_DATA0 = 3'd3,
    PID_DATA1 = 3'd4,
    PID_ACK   = 3'd5,
    PID_NAK   = 3'd6,
    PID_STALL = 3'd7
  } usb_pid_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_ACTIVE,
    ST_TX_START,
    ST_TX_ACTIVE,
    ST_WAIT_HS,
    ST_ERROR
  } ctrl_state_t;

  function automatic logic is_handshake(usb_pid_t pid);
    return (pid == PID_ACK) || (pid == PID_NAK) || (pid == PID_STALL);
  endfunction

  function automatic logic is_data(usb_pid_t pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

  // Buffer owned by the USB side whenever a packet phase is in progress.
  function automatic logic usb_owns(ctrl_state_t s);
    return (s == ST_RX_ACTIVE) || (s == ST_TX_START) ||
           (s == ST_TX_ACTIVE) || (s == ST_WAIT_HS);
  endfunction

endpackage

// File: rtl/usb_timeout_cnt.sv
// usb_timeout_cnt: loadable up-counter that saturates at all-ones.
//   clk   - system clock
//   rst   - synchronous active-high reset, count -> 0
//   load  - synchronous clear to 0 (priority over en)
//   en    - count up by one, holding at the maximum value
//   count - current count
module usb_timeout_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/usb_prot_ctrl.sv
// usb_prot_ctrl: sequences the shared USB data buffer between RX, TX and host.
// Optional feature macro: USB_NAK_RETRY_EN (NAK after a DATA packet relaunches
// the same DATA PID up to 3 times, the 4th NAK is an error).
//   clk, rst                 - clock, synchronous active-high reset
//   rx_packet                - decoded PID from RX
//   rx_data_ready            - RX packet complete pulse
//   rx_transfer_active       - RX packet in progress
//   rx_error                 - RX error pulse
//   tx_transfer_active       - TX serializer busy
//   tx_error                 - TX error pulse
//   buffer_occupancy         - bytes in buffer
//   host_tx_req, host_tx_pid - host send request and PID
//   host_ack_clr             - host clears rx_done / ctrl_error
//   tx_packet, tx_start      - PID to TX and launch pulse
//   clear                    - buffer flush pulse
//   d_mode                   - buffer owner (0 host, 1 USB)
//   host_busy                - controller not idle
//   rx_pid_latched, rx_size  - PID and size of last good RX packet
//   rx_done, ctrl_error      - sticky status / error flags
module usb_prot_ctrl
  import usb_pkg::*;
#(
  parameter int BUF_DEPTH      = usb_pkg::BUF_DEPTH,
  parameter int TIMEOUT_CYCLES = 150,
  parameter int TX_START_WAIT  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] rx_packet,
  input  logic       rx_data_ready,
  input  logic       rx_transfer_active,
  input  logic       rx_error,
  input  logic       tx_transfer_active,
  input  logic       tx_error,
  input  logic [6:0] buffer_occupancy,
  input  logic       host_tx_req,
  input  logic [2:0] host_tx_pid,
  input  logic       host_ack_clr,
  output logic [2:0] tx_packet,
  output logic       tx_start,
  output logic       clear,
  output logic       d_mode,
  output logic       host_busy,
  output logic [2:0] rx_pid_latched,
  output logic [6:0] rx_size,
  output logic       rx_done,
  output logic       ctrl_error
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > TX_START_WAIT) ? TIMEOUT_CYCLES : TX_START_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ctrl_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_load;
  logic             cnt_en;

`ifdef USB_NAK_RETRY_EN
  logic [1:0] retry_cnt;
  logic       from_hs;
`endif

  // One counter serves both timed states; it is held at zero elsewhere so
  // it always starts from 0 on entry.
  always_comb begin
    cnt_en   = (state == ST_TX_START) || (state == ST_WAIT_HS);
    cnt_load = !cnt_en;
  end

  usb_timeout_cnt #(
    .WIDTH(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .count(cnt)
  );

  // State and the state-derived outputs move together so they stay registered.
  task automatic goto_state(input ctrl_state_t s);
    state     <= s;
    d_mode    <= usb_owns(s);
    host_busy <= (s != ST_IDLE);
    if (s == ST_ERROR) ctrl_error <= 1'b1;
  endtask

  task automatic latch_rx();
    rx_pid_latched <= rx_packet;
    rx_size        <= buffer_occupancy;
    rx_done        <= 1'b1;
  endtask

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      tx_packet      <= PID_NONE;
      tx_start       <= 1'b0;
      clear          <= 1'b0;
      d_mode         <= 1'b0;
      host_busy      <= 1'b0;
      rx_pid_latched <= '0;
      rx_size        <= '0;
      rx_done        <= 1'b0;
      ctrl_error     <= 1'b0;
`ifdef USB_NAK_RETRY_EN
      retry_cnt      <= '0;
      from_hs        <= 1'b0;
`endif
    end else begin
      tx_start <= 1'b0;
      clear    <= 1'b0;
      // Any flag set later in this block takes precedence over the host clear.
      if (host_ack_clr) begin
        rx_done    <= 1'b0;
        ctrl_error <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
`ifdef USB_NAK_RETRY_EN
          from_hs <= 1'b0;
`endif
          if (rx_transfer_active) begin
            if (host_tx_req) ctrl_error <= 1'b1;
            goto_state(ST_RX_ACTIVE);
          end else if (host_tx_req) begin
            tx_packet <= host_tx_pid;
            tx_start  <= 1'b1;
            // Only handshakes flush: a DATA send must keep the buffered payload.
            clear     <= is_handshake(usb_pid_t'(host_tx_pid));
`ifdef USB_NAK_RETRY_EN
            retry_cnt <= '0;
`endif
            goto_state(ST_TX_START);
          end
        end

        ST_RX_ACTIVE: begin
          if (rx_error || (buffer_occupancy > 7'(BUF_DEPTH))) begin
            clear <= rx_error;
            goto_state(ST_ERROR);
          end else if (rx_data_ready) begin
`ifdef USB_NAK_RETRY_EN
            if (from_hs && (rx_packet == PID_NAK)) begin
              if (retry_cnt == 2'd3) begin
                goto_state(ST_ERROR);
              end else begin
                retry_cnt <= retry_cnt + 2'd1;
                tx_start  <= 1'b1;
                goto_state(ST_TX_START);
              end
            end else begin
              latch_rx();
              goto_state(ST_IDLE);
            end
`else
            latch_rx();
            goto_state(ST_IDLE);
`endif
          end
        end

        ST_TX_START: begin
          if (tx_transfer_active) begin
            goto_state(ST_TX_ACTIVE);
          end else if (cnt == CNT_W'(TX_START_WAIT - 1)) begin
            goto_state(ST_ERROR);
          end
        end

        ST_TX_ACTIVE: begin
          if (tx_error) begin
            goto_state(ST_ERROR);
          end else if (!tx_transfer_active) begin
            if (is_data(usb_pid_t'(tx_packet))) goto_state(ST_WAIT_HS);
            else                                goto_state(ST_IDLE);
          end
        end

        ST_WAIT_HS: begin
          if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            goto_state(ST_ERROR);
          end else if (rx_transfer_active) begin
`ifdef USB_NAK_RETRY_EN
            from_hs <= 1'b1;
`endif
            goto_state(ST_RX_ACTIVE);
          end
        end

        ST_ERROR: begin
          if (host_ack_clr) goto_state(ST_IDLE);
        end

        default: goto_state(ST_IDLE);
      endcase
    end
  end

endmodule

// File: tb/tb_usb_prot_ctrl.sv
// tb_usb_prot_ctrl: scoreboard bench for usb_prot_ctrl (default build).
// Each step drives inputs, pushes the expected output snapshot, advances
// the clock and compares against the popped expectation.
module tb_usb_prot_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] rx_packet;
  logic       rx_data_ready;
  logic       rx_transfer_active;
  logic       rx_error;
  logic       tx_transfer_active;
  logic       tx_error;
  logic [6:0] buffer_occupancy;
  logic       host_tx_req;
  logic [2:0] host_tx_pid;
  logic       host_ack_clr;
  logic [2:0] tx_packet;
  logic       tx_start;
  logic       clear;
  logic       d_mode;
  logic       host_busy;
  logic [2:0] rx_pid_latched;
  logic [6:0] rx_size;
  logic       rx_done;
  logic       ctrl_error;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    int          n;
    logic        rst;
    logic        rxa;
    logic        rdy;
    logic        rerr;
    logic [2:0]  rpid;
    logic        txa;
    logic        terr;
    logic [6:0]  occ;
    logic        req;
    logic [2:0]  hpid;
    logic        ack;
    logic [18:0] exp;
  } step_t;

  typedef struct {
    string       tag;
    logic [18:0] exp;
  } sb_t;

  sb_t sbq[$];

  usb_prot_ctrl #(
    .BUF_DEPTH     (64),
    .TIMEOUT_CYCLES(150),
    .TX_START_WAIT (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_packet         (rx_packet),
    .rx_data_ready     (rx_data_ready),
    .rx_transfer_active(rx_transfer_active),
    .rx_error          (rx_error),
    .tx_transfer_active(tx_transfer_active),
    .tx_error          (tx_error),
    .buffer_occupancy  (buffer_occupancy),
    .host_tx_req       (host_tx_req),
    .host_tx_pid       (host_tx_pid),
    .host_ack_clr      (host_ack_clr),
    .tx_packet         (tx_packet),
    .tx_start          (tx_start),
    .clear             (clear),
    .d_mode            (d_mode),
    .host_busy         (host_busy),
    .rx_pid_latched    (rx_pid_latched),
    .rx_size           (rx_size),
    .rx_done           (rx_done),
    .ctrl_error        (ctrl_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected snapshot: tx_packet, tx_start, clear, d_mode, host_busy,
  // rx_pid_latched, rx_size, rx_done, ctrl_error.
  function automatic logic [18:0] mk(int txp, int ts, int clr, int dm, int bz,
                                     int pid, int sz, int dn, int er);
    return {3'(txp), 1'(ts), 1'(clr), 1'(dm), 1'(bz), 3'(pid), 7'(sz), 1'(dn), 1'(er)};
  endfunction

  function automatic logic [18:0] snap();
    return {tx_packet, tx_start, clear, d_mode, host_busy,
            rx_pid_latched, rx_size, rx_done, ctrl_error};
  endfunction

  function automatic step_t st(string tag, int n, int r, int rxa, int rdy, int rerr,
                               int rpid, int txa, int terr, int occ, int req,
                               int hpid, int ack, logic [18:0] exp);
    step_t s;
    s.tag  = tag;   s.n    = n;
    s.rst  = 1'(r); s.rxa  = 1'(rxa); s.rdy = 1'(rdy); s.rerr = 1'(rerr);
    s.rpid = 3'(rpid); s.txa = 1'(txa); s.terr = 1'(terr); s.occ = 7'(occ);
    s.req  = 1'(req); s.hpid = 3'(hpid); s.ack = 1'(ack); s.exp = exp;
    return s;
  endfunction

  task automatic apply(input step_t s);
    rst                = s.rst;
    rx_transfer_active = s.rxa;
    rx_data_ready      = s.rdy;
    rx_error           = s.rerr;
    rx_packet          = s.rpid;
    tx_transfer_active = s.txa;
    tx_error           = s.terr;
    buffer_occupancy   = s.occ;
    host_tx_req        = s.req;
    host_tx_pid        = s.hpid;
    host_ack_clr       = s.ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    sb_t   e;
    s.push_back(st("rst_hold", 2, 1,0,0,0,0, 0,0, 0, 0,0,0, mk(0,0,0,0,0,0,0,0,0)));
    s.push_back(st("rst_req",  1, 1,0,0,0,0, 0,0, 0, 1,5,0, mk(0,0,0,0,0,0,0,0,0)));
    s.push_back(st("rst_idle", 2, 0,0,0,0,0, 0,0, 0, 0,0,0, mk(0,0,0,0,0,0,0,0,0)));
    foreach (s[i]) begin
      apply(s[i]);
      sbq.push_back('{s[i].tag, s[i].exp});
      repeat (s[i].n) tick();
      e = sbq.pop_front();
      checks++;
      if (snap() !== e.exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", e.tag, snap(), e.exp);
      end
    end
  endtask

  task automatic test_rx_data0();
    step_t s[$];
    sb_t   e;
    s.push_back(st("rx_start", 1, 0,1,0,0,0, 0,0, 0, 0,0,0, mk(0,0,0,1,1,0,0,0,0)));
    s.push_back(st("rx_busy",  3, 0,1,0,0,0, 0,0, 1, 0,0,0, mk(0,0,0,1,1,0,0,0,0)));
    s.push_back(st("rx_ready", 1, 0,0,1,0,3, 0,0, 1, 0,0,0, mk(0,0,0,0,0,3,1,1,0)));
    s.push_back(st("rx_idle",  2, 0,0,0,0,0, 0,0, 1, 0,0,0, mk(0,0,0,0,0,3,1,1,0)));
    foreach (s[i]) begin
      apply(s[i]);
      sbq.push_back('{s[i].tag, s[i].exp});
      repeat (s[i].n) tick();
      e = sbq.pop_front();
      checks++;
      if (snap() !== e.exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", e.tag, snap(), e.exp);
      end
    end
  endtask

  task automatic test_tx_handshake();
    step_t s[$];
    sb_t   e;
    s.push_back(st("ack_launch", 1, 0,0,0,0,0, 0,0, 1, 1,5,0, mk(5,1,1,1,1,3,1,1,0)));
    s.push_back(st("ack_wait",   2, 0,0,0,0,0, 0,0, 1, 0,0,0, mk(5,0,0,1,1,3,1,1,0)));
    s.push_back(st("ack_txa",    2, 0,0,0,0,0, 1,0, 1, 0,0,0, mk(5,0,0,1,1,3,1,1,0)));
    s.push_back(st("ack_done",   1, 0,0,0,0,0, 0,0, 1, 0,0,0, mk(5,0,0,0,0,3,1,1,0)));
    foreach (s[i]) begin
      apply(s[i]);
      sbq.push_back('{s[i].tag, s[i].exp});
      repeat (s[i].n) tick();
      e = sbq.pop_front();
      checks++;
      if (snap() !== e.exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", e.tag, snap(), e.exp);
      end
    end
  endtask

  task automatic test_hs_timeout();
    step_t s[$];
    sb_t   e;
    s.push_back(st("d1_launch",  1,   0,0,0,0,0, 0,0, 64, 1,4,0, mk(4,1,0,1,1,3,1,1,0)));
    s.push_back(st("d1_txa",     1,   0,0,0,0,0, 1,0, 64, 0,0,0, mk(4,0,0,1,1,3,1,1,0)));
    s.push_back(st("d1_fall",    1,   0,0,0,0,0, 0,0, 64, 0,0,0, mk(4,0,0,1,1,3,1,1,0)));
    s.push_back(st("hs_149",     149, 0,0,0,0,0, 0,0, 64, 0,0,0, mk(4,0,0,1,1,3,1,1,0)));
    s.push_back(st("hs_timeout", 1,   0,0,0,0,0, 0,0, 64, 0,0,0, mk(4,0,0,0,1,3,1,1,1)));
    s.push_back(st("hs_errhold", 3,   0,0,0,0,0, 0,0, 64, 0,0,0, mk(4,0,0,0,1,3,1,1,1)));
    s.push_back(st("hs_ack",     1,   0,0,0,0,0, 0,0, 64, 0,0,1, mk(4,0,0,0,0,3,1,0,0)));
    foreach (s[i]) begin
      apply(s[i]);
      sbq.push_back('{s[i].tag, s[i].exp});
      repeat (s[i].n) tick();
      e = sbq.pop_front();
      checks++;
      if (snap() !== e.exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", e.tag, snap(), e.exp);
      end
    end
  endtask

  task automatic test_tx_start_guard();
    step_t s[$];
    sb_t   e;
    s.push_back(st("g_launch", 1, 0,0,0,0,0, 0,0, 1, 1,3,0, mk(3,1,0,1,1,3,1,0,0)));
    s.push_back(st("g_wait7",  7, 0,0,0,0,0, 0,0, 1, 0,0,0, mk(3,0,0,1,1,3,1,0,0)));
    s.push_back(st("g_err",    1, 0,0,0,0,0, 0,0, 1, 0,0,0, mk(3,0,0,0,1,3,1,0,1)));
    s.push_back(st("g_ack",    1, 0,0,0,0,0, 0,0, 1, 0,0,1, mk(3,0,0,0,0,3,1,0,0)));
    foreach (s[i]) begin
      apply(s[i]);
      sbq.push_back('{s[i].tag, s[i].exp});
      repeat (s[i].n) tick();
      e = sbq.pop_front();
      checks++;
      if (snap() !== e.exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", e.tag, snap(), e.exp);
      end
    end
  endtask

  task automatic test_rx_error();
    step_t s[$];
    sb_t   e;
    s.push_back(st("e_rx",   1, 0,1,0,0,0, 0,0, 10, 0,0,0, mk(3,0,0,1,1,3,1,0,0)));
    s.push_back(st("e_rdy",  1, 0,0,1,0,4, 0,0, 10, 0,0,0, mk(3,0,0,0,0,4,10,1,0)));
    s.push_back(st("e_rx2",  1, 0,1,0,0,0, 0,0, 5,  0,0,0, mk(3,0,0,1,1,4,10,1,0)));
    s.push_back(st("e_err",  1, 0,1,1,1,7, 0,0, 5,  0,0,0, mk(3,0,1,0,1,4,10,1,1)));
    s.push_back(st("e_hold", 1, 0,0,0,0,0, 0,0, 5,  0,0,0, mk(3,0,0,0,1,4,10,1,1)));
    s.push_back(st("e_ack",  1, 0,0,0,0,0, 0,0, 5,  0,0,1, mk(3,0,0,0,0,4,10,0,0)));
    s.push_back(st("o_full", 2, 0,1,0,0,0, 0,0, 64, 0,0,0, mk(3,0,0,1,1,4,10,0,0)));
    s.push_back(st("o_ovf",  1, 0,1,0,0,0, 0,0, 65, 0,0,0, mk(3,0,0,0,1,4,10,0,1)));
    s.push_back(st("o_ack",  1, 0,0,0,0,0, 0,0, 0,  0,0,1, mk(3,0,0,0,0,4,10,0,0)));
    foreach (s[i]) begin
      apply(s[i]);
      sbq.push_back('{s[i].tag, s[i].exp});
      repeat (s[i].n) tick();
      e = sbq.pop_front();
      checks++;
      if (snap() !== e.exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", e.tag, snap(), e.exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    step_t s[$];
    sb_t   e;
    s.push_back(st("s_both", 1, 0,1,0,0,0, 0,0, 0, 1,5,0, mk(3,0,0,1,1,4,10,0,1)));
    s.push_back(st("s_rdy",  1, 0,0,1,0,2, 0,0, 0, 0,0,0, mk(3,0,0,0,0,2,0,1,1)));
    s.push_back(st("s_ack",  1, 0,0,0,0,0, 0,0, 0, 0,0,1, mk(3,0,0,0,0,2,0,0,0)));
    foreach (s[i]) begin
      apply(s[i]);
      sbq.push_back('{s[i].tag, s[i].exp});
      repeat (s[i].n) tick();
      e = sbq.pop_front();
      checks++;
      if (snap() !== e.exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", e.tag, snap(), e.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s[$];
    sb_t   e;
    s.push_back(st("h_launch", 1,  0,0,0,0,0, 0,0, 8, 1,3,0, mk(3,1,0,1,1,2,0,0,0)));
    s.push_back(st("h_txa",    1,  0,0,0,0,0, 1,0, 8, 0,0,0, mk(3,0,0,1,1,2,0,0,0)));
    s.push_back(st("h_fall",   1,  0,0,0,0,0, 0,0, 8, 0,0,0, mk(3,0,0,1,1,2,0,0,0)));
    s.push_back(st("h_wait",   20, 0,0,0,0,0, 0,0, 8, 0,0,0, mk(3,0,0,1,1,2,0,0,0)));
    s.push_back(st("h_rx",     1,  0,1,0,0,0, 0,0, 0, 0,0,0, mk(3,0,0,1,1,2,0,0,0)));
    s.push_back(st("h_nak",    1,  0,0,1,0,6, 0,0, 0, 0,0,0, mk(3,0,0,0,0,6,0,1,0)));
    s.push_back(st("b_launch", 1,  0,0,0,0,0, 0,0, 0, 1,7,0, mk(7,1,1,1,1,6,0,1,0)));
    s.push_back(st("b_txa",    1,  0,0,0,0,0, 1,0, 0, 0,0,0, mk(7,0,0,1,1,6,0,1,0)));
    s.push_back(st("b_done",   1,  0,0,0,0,0, 0,0, 0, 0,0,0, mk(7,0,0,0,0,6,0,1,0)));
    s.push_back(st("t_launch", 1,  0,0,0,0,0, 0,0, 0, 1,4,0, mk(4,1,0,1,1,6,0,1,0)));
    s.push_back(st("t_txa",    1,  0,0,0,0,0, 1,0, 0, 0,0,0, mk(4,0,0,1,1,6,0,1,0)));
    s.push_back(st("t_err",    1,  0,0,0,0,0, 1,1, 0, 0,0,0, mk(4,0,0,0,1,6,0,1,1)));
    s.push_back(st("t_ack",    1,  0,0,0,0,0, 0,0, 0, 0,0,1, mk(4,0,0,0,0,6,0,0,0)));
    foreach (s[i]) begin
      apply(s[i]);
      sbq.push_back('{s[i].tag, s[i].exp});
      repeat (s[i].n) tick();
      e = sbq.pop_front();
      checks++;
      if (snap() !== e.exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", e.tag, snap(), e.exp);
      end
    end
  endtask

  task automatic test_rst_mid();
    step_t s[$];
    sb_t   e;
    s.push_back(st("r_launch", 1, 0,0,0,0,0, 0,0, 0, 1,3,0, mk(3,1,0,1,1,6,0,0,0)));
    s.push_back(st("r_txa",    1, 0,0,0,0,0, 1,0, 0, 0,0,0, mk(3,0,0,1,1,6,0,0,0)));
    s.push_back(st("r_rst",    1, 1,0,0,0,0, 1,0, 0, 0,0,0, mk(0,0,0,0,0,0,0,0,0)));
    s.push_back(st("r_idle",   1, 0,0,0,0,0, 0,0, 0, 0,0,0, mk(0,0,0,0,0,0,0,0,0)));
    s.push_back(st("r_req",    1, 0,0,0,0,0, 0,0, 0, 1,5,0, mk(5,1,1,1,1,0,0,0,0)));
    s.push_back(st("r_txa2",   1, 0,0,0,0,0, 1,0, 0, 0,0,0, mk(5,0,0,1,1,0,0,0,0)));
    s.push_back(st("r_end",    1, 0,0,0,0,0, 0,0, 0, 0,0,0, mk(5,0,0,0,0,0,0,0,0)));
    foreach (s[i]) begin
      apply(s[i]);
      sbq.push_back('{s[i].tag, s[i].exp});
      repeat (s[i].n) tick();
      e = sbq.pop_front();
      checks++;
      if (snap() !== e.exp) begin
        failures++;
        $display("FAIL %s got=%h exp=%h", e.tag, snap(), e.exp);
      end
    end
  endtask

  initial begin
    rst                = 1'b1;
    rx_packet          = '0;
    rx_data_ready      = 1'b0;
    rx_transfer_active = 1'b0;
    rx_error           = 1'b0;
    tx_transfer_active = 1'b0;
    tx_error           = 1'b0;
    buffer_occupancy   = '0;
    host_tx_req        = 1'b0;
    host_tx_pid        = '0;
    host_ack_clr       = 1'b0;

    test_reset();
    test_rx_data0();
    test_tx_handshake();
    test_hs_timeout();
    test_tx_start_guard();
    test_rx_error();
    test_simultaneous();
    test_back_to_back();
    test_rst_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
